// File: rtl/qsys_onchip_memory_pipe_if.sv
// Avalon-MM slave command/response bundle for the on-chip RAM.
interface qsys_onchip_memory_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/qsys_onchip_memory_pipe.sv
// Avalon-MM on-chip RAM slave with pipelined reads and a post-reset fill sweep.
// Define ONCHIP_MEM_PARITY_EN to store per-byte even parity and report read errors.
module qsys_onchip_memory_pipe #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 10,
  parameter int unsigned       READ_LATENCY   = 1,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,
  qsys_onchip_memory_pipe_if.slave  bus,
`ifdef ONCHIP_MEM_PARITY_EN
  input  logic                      parity_err_clr,
  output logic                      parity_err,
`endif
  output logic                      init_done
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int unsigned RAM_W = DATA_W + NB;
`else
  localparam int unsigned RAM_W = DATA_W;
`endif
  localparam bit              Clear   = (CLEAR_ON_RESET != 0);
  localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

  function automatic logic [RAM_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [RAM_W-1:0] w;
    w = '0;
    w[DATA_W-1:0] = d;
`ifdef ONCHIP_MEM_PARITY_EN
    for (int i = 0; i < NB; i++) w[DATA_W+i] = ^d[8*i +: 8];
`endif
    return w;
  endfunction

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q;
  logic [ADDR_W:0] ptr_q;

  logic adv, run, wait_req, accept, wr_acc, rd_acc, sweep_we;

  assign adv      = clken & ~reset_req;
  assign run      = (state_q == StRun);
  assign wait_req = ~(run & adv);
  assign accept   = bus.chipselect & ~wait_req & (bus.read | bus.write);
  assign wr_acc   = accept & bus.write;
  // A combined read+write is treated as a write only.
  assign rd_acc   = accept & bus.read & ~bus.write;
  assign sweep_we = (state_q == StInit) & adv & Clear;

  assign bus.waitrequest = wait_req;
  assign init_done       = run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else if (adv && state_q == StInit) begin
      if (!Clear || ptr_q == LastPtr) state_q <= StRun;
      if (Clear) ptr_q <= ptr_q + PtrOne;
    end
  end

  // RAM write port, shared between the fill sweep and bus writes.
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [RAM_W-1:0]    ram_wdata;
  logic [NB-1:0]       ram_be;
  logic [RAM_W-1:0]    mem [DEPTH];

  always_comb begin
    ram_we    = sweep_we | wr_acc;
    ram_addr  = bus.address;
    ram_wdata = encode(bus.writedata);
    ram_be    = bus.byteenable;
    if (sweep_we) begin
      ram_addr  = ptr_q[ADDR_W-1:0];
      ram_wdata = encode(INIT_VALUE);
      ram_be    = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
          mem[ram_addr][DATA_W+i] <= ram_wdata[DATA_W+i];
`endif
        end
      end
    end
  end

  // Read pipeline: stage 1 is the synchronous RAM read, optional stage 2 adds a register.
  logic             s1_valid_q;
  logic [RAM_W-1:0] s1_data_q;
  logic             last_valid;
  logic [RAM_W-1:0] last_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= rd_acc;
      if (rd_acc) s1_data_q <= mem[bus.address];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s2_valid_q;
    logic [RAM_W-1:0] s2_data_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else if (adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign last_valid = s2_valid_q;
    assign last_data  = s2_data_q;
  end else begin : g_lat1
    assign last_valid = s1_valid_q;
    assign last_data  = s1_data_q;
  end

  // A response is only presented on an advancing cycle so a frozen pipeline never repeats it.
  assign bus.readdatavalid = last_valid & adv;
  assign bus.readdata      = last_data[DATA_W-1:0];

`ifdef ONCHIP_MEM_PARITY_EN
  logic par_bad, par_err_q, par_set;

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NB; i++) par_bad = par_bad | ((^last_data[8*i +: 8]) ^ last_data[DATA_W+i]);
  end

  assign par_set = bus.readdatavalid & par_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= (par_err_q & ~parity_err_clr) | par_set;
  end

  assign parity_err = par_err_q | par_set;
`endif

endmodule
